// File: rtl/approx_mul_pkg.sv
// Shared definitions for the approximate multiplier: pair-compression rule
// and statistics width. Optional error monitor: APPROX_MUL_ERR_MON_EN.
package approx_mul_pkg;

  localparam int unsigned STAT_W = 32;
  // Widest product the compression helper handles (operands up to 32 bits).
  localparam int unsigned MAX_PW = 64;

  // Combine two partial-product rows. a_row/b_row are the unshifted masked
  // multiplicand rows; a sits at weight 'base', b at 'base+1'. Columns below
  // approx_col OR their bits (carry dropped) when approx_en is set; all other
  // columns add exactly.
  function automatic logic [MAX_PW-1:0] pair_comp(
    input logic [MAX_PW-1:0] a_row,
    input logic [MAX_PW-1:0] b_row,
    input int unsigned       base,
    input int unsigned       approx_col,
    input logic              approx_en
  );
    logic [MAX_PW-1:0] a;
    logic [MAX_PW-1:0] b;
    logic [MAX_PW-1:0] mask;
    a = a_row << base;
    b = b_row << (base + 1);
    if (!approx_en)
      mask = '0;
    else if (approx_col >= MAX_PW)
      mask = '1;
    else
      mask = (64'd1 << approx_col) - 64'd1;
    return ((a | b) & mask) + (a & ~mask) + (b & ~mask);
  endfunction

endpackage

// File: rtl/approx_mul_pipe_pair_comp.sv
// Combinational compressor for one pair of low partial-product rows.
module approx_pair_comp
  import approx_mul_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned APPROX_COL = 6,
  parameter int unsigned BASE       = 0
) (
  input  logic [W-1:0]   y,
  input  logic           x_a,
  input  logic           x_b,
  input  logic           approx_en,
  output logic [2*W-1:0] sum
);

  logic [MAX_PW-1:0] full;

  assign full = pair_comp(MAX_PW'(y & {W{x_a}}), MAX_PW'(y & {W{x_b}}),
                          BASE, APPROX_COL, approx_en);
  assign sum  = full[2*W-1:0];

  // Pair sums always fit in 2W bits; the helper's upper bits are zero.
  if (2*W < MAX_PW) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^full[MAX_PW-1:2*W];
  end

endmodule

// File: rtl/approx_mul_pipe.sv
// Two-stage valid/ready approximate multiplier with per-transaction
// exact/approximate select. Optional error monitor: APPROX_MUL_ERR_MON_EN.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned L          = 4,
  parameter int unsigned APPROX_COL = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   z,
  output logic             out_approx
`ifdef APPROX_MUL_ERR_MON_EN
  ,
  input  logic             clear_stats,
  output logic [STAT_W-1:0] err_acc,
  output logic [STAT_W-1:0] sample_cnt
`endif
);

  localparam int unsigned NP = L / 2;
  localparam int unsigned PW = 2 * W;

  logic          en;
  logic [PW-1:0] high_d;
  logic [PW-1:0] pair_d [NP];
  logic          s1_valid;
  logic          s1_approx;
  logic [PW-1:0] s1_high;
  logic [PW-1:0] s1_pair [NP];
  logic [PW-1:0] sum_d;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // High rows are always exact, already weighted by 2^L.
  if (L < W) begin : g_high
    assign high_d = (PW'(y) * PW'(x[W-1:L])) << L;
  end else begin : g_no_high
    assign high_d = '0;
  end

  for (genvar k = 0; k < NP; k++) begin : g_pair
    approx_pair_comp #(
      .W          (W),
      .APPROX_COL (APPROX_COL),
      .BASE       (2 * k)
    ) u_pair (
      .y         (y),
      .x_a       (x[2*k]),
      .x_b       (x[2*k+1]),
      .approx_en (approx_en),
      .sum       (pair_d[k])
    );
  end

  // Stage 1: capture high part, pair sums and mode of an accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_approx <= 1'b0;
      s1_high   <= '0;
      for (int unsigned k = 0; k < NP; k++) s1_pair[k] <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_approx <= approx_en;
        s1_high   <= high_d;
        for (int unsigned k = 0; k < NP; k++) s1_pair[k] <= pair_d[k];
      end
    end
  end

  // Final accumulation of the stage-1 terms.
  always_comb begin
    sum_d = s1_high;
    for (int unsigned k = 0; k < NP; k++) sum_d = sum_d + s1_pair[k];
  end

  // Stage 2: output register; bubbles leave z/out_approx untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      z          <= '0;
      out_approx <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        z          <= sum_d;
        out_approx <= s1_approx;
      end
    end
  end

`ifdef APPROX_MUL_ERR_MON_EN
  localparam logic [MAX_PW:0] STAT_MAX = (MAX_PW+1)'({STAT_W{1'b1}});

  logic [PW-1:0]     s1_exact;
  logic [PW-1:0]     s2_exact;
  logic [PW-1:0]     err_diff;
  logic [MAX_PW:0]   err_sum;
  logic              mon_hs;

  assign mon_hs   = out_valid && out_ready && out_approx;
  assign err_diff = s2_exact - z;
  assign err_sum  = (MAX_PW+1)'(err_acc) + (MAX_PW+1)'(err_diff);

  // Exact product travels alongside the approximate one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_exact <= '0;
      s2_exact <= '0;
    end else if (en) begin
      if (in_valid) s1_exact <= PW'(x) * PW'(y);
      if (s1_valid) s2_exact <= s1_exact;
    end
  end

  // Saturating error statistics; clear has priority over a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_acc    <= '0;
      sample_cnt <= '0;
    end else if (clear_stats) begin
      err_acc    <= '0;
      sample_cnt <= '0;
    end else if (mon_hs) begin
      err_acc    <= (err_sum > STAT_MAX) ? '1 : err_sum[STAT_W-1:0];
      sample_cnt <= (sample_cnt == '1) ? sample_cnt : sample_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Self-checking bench for approx_mul_pipe: two instances (APPROX_COL=6 and 0)
// driven with identical stimulus, each checked against a column-level model.
module tb_approx_mul_pipe;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [15:0] z;
    logic        a;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready0;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        approx_en;
  logic        out_valid;
  logic        out_valid0;
  logic        out_ready;
  logic [15:0] z;
  logic [15:0] z0;
  logic        out_approx;
  logic        out_approx0;
`ifdef APPROX_MUL_ERR_MON_EN
  logic        clear_stats;
  logic [31:0] err_acc;
  logic [31:0] sample_cnt;
  logic [31:0] err_acc0;
  logic [31:0] sample_cnt0;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  exp_t exp_q[$];
  exp_t exp0_q[$];

  always #5 clk = ~clk;

  approx_mul_pipe #(.W(8), .L(4), .APPROX_COL(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .z(z), .out_approx(out_approx)
`ifdef APPROX_MUL_ERR_MON_EN
    , .clear_stats(clear_stats), .err_acc(err_acc), .sample_cnt(sample_cnt)
`endif
  );

  approx_mul_pipe #(.W(8), .L(4), .APPROX_COL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .x(x), .y(y), .approx_en(approx_en), .out_valid(out_valid0),
    .out_ready(out_ready), .z(z0), .out_approx(out_approx0)
`ifdef APPROX_MUL_ERR_MON_EN
    , .clear_stats(clear_stats), .err_acc(err_acc0), .sample_cnt(sample_cnt0)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Column-by-column reference: high rows exact, low rows paired and either
  // ORed (below col, approximate mode) or added.
  function automatic logic [15:0] ref_mul(input logic [7:0] xv, input logic [7:0] yv,
                                          input logic ae, input int unsigned col);
    int unsigned acc;
    int unsigned abit;
    int unsigned bbit;
    acc = (int'(yv) * int'(xv >> 4)) * 16;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 16; j++) begin
        abit = 0;
        bbit = 0;
        if (j >= 2*k && j - 2*k < 8)       abit = xv[2*k] & yv[j-2*k];
        if (j >= 2*k+1 && j - 2*k - 1 < 8) bbit = xv[2*k+1] & yv[j-2*k-1];
        if (ae && j < col) acc += (abit | bbit) << j;
        else               acc += (abit + bbit) << j;
      end
    end
    return acc[15:0];
  endfunction

  // Scoreboard: outputs must match the queue head; accepted inputs enqueue.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, !out_valid || out_ready);
      check("in_ready0", in_ready0, !out_valid0 || out_ready);
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
        else begin
          check("z", z, exp_q[0].z);
          check("out_approx", out_approx, exp_q[0].a);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (out_valid0) begin
        if (exp0_q.size() == 0) check("spurious_out0", out_valid0, 0);
        else begin
          check("z_col0", z0, exp0_q[0].z);
          if (out_ready) void'(exp0_q.pop_front());
        end
      end
      if (in_valid && in_ready)  exp_q.push_back('{ref_mul(x, y, approx_en, 6), approx_en});
      if (in_valid && in_ready0) exp0_q.push_back('{ref_mul(x, y, approx_en, 0), approx_en});
    end
  end

  // Present one transaction and hold it until accepted (bounded).
  task automatic send(input logic [7:0] xv, input logic [7:0] yv, input logic ae);
    logic acc;
    acc = 1'b0;
    x = xv; y = yv; approx_en = ae; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) check("send_timeout", acc, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Single transaction with latency and fixed-value checks.
  task automatic run_one(input logic [7:0] xv, input logic [7:0] yv, input logic ae,
                         input logic [15:0] zexp, input string tag);
    int lat;
    lat = 0;
    send(xv, yv, ae);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check({tag, "_lat"}, lat, 2);
    check({tag, "_z"}, z, zexp);
    check({tag, "_appr"}, out_approx, ae);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && (exp_q.size() != 0 || exp0_q.size() != 0); i++) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
    check("drain0", exp0_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; approx_en = 1'b0; out_ready = 1'b1;
`ifdef APPROX_MUL_ERR_MON_EN
    clear_stats = 1'b0;
`endif
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_z", z, 0);
    check("rst_out_approx", out_approx, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_one(8'd3, 8'd3, 1'b1, 16'd7, "x3y3_apx");
    run_one(8'd3, 8'd3, 1'b0, 16'd9, "x3y3_ex");
`ifdef APPROX_MUL_ERR_MON_EN
    clear_stats = 1'b1;
    @(posedge clk); #1;
    clear_stats = 1'b0;
`endif
    run_one(8'd255, 8'd255, 1'b1, 16'd64907, "max_apx");
`ifdef APPROX_MUL_ERR_MON_EN
    check("mon_err_acc", err_acc, 118);
    check("mon_sample_cnt", sample_cnt, 1);
`endif
    run_one(8'd255, 8'd255, 1'b0, 16'd65025, "max_ex");
    wait_drain();

    // Back-to-back random stream.
    for (int i = 0; i < 100; i++)
      send(8'($urandom), 8'($urandom), 1'($urandom));
    wait_drain();

    // Stall with three transactions outstanding.
    out_ready = 1'b0;
    send(8'($urandom), 8'($urandom), 1'b1);
    send(8'($urandom), 8'($urandom), 1'b0);
    fork
      send(8'($urandom), 8'($urandom), 1'b1);
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

`ifdef APPROX_MUL_ERR_MON_EN
    // Clear coinciding with an approximate handshake.
    out_ready = 1'b0;
    send(8'd255, 8'd255, 1'b1);
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    clear_stats = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    check("clr_err_acc", err_acc, 0);
    check("clr_sample_cnt", sample_cnt, 0);
    wait_drain();
`endif

    // Reset while two transactions are in flight.
    send(8'($urandom), 8'($urandom), 1'b1);
    send(8'($urandom), 8'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_z", z, 0);
    check("mid_rst_z0", z0, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    exp0_q.delete();
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_z", z, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
